// File: rtl/parc_core_rob_result_buffer.sv
// Result payload store for the reorder buffer: captures writeback data by ROB
// slot, retires it to the architectural register file write port on commit,
// and offers a combinational operand bypass lookup.
module parc_core_rob_result_buffer #(
  parameter int unsigned NSLOTS = 16,
  parameter int unsigned SLOTW  = 4,
  parameter int unsigned DW     = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fill_val_i,
  input  logic [SLOTW-1:0] fill_slot_i,
  input  logic [DW-1:0]    fill_data_i,
  input  logic             commit_wen_i,
  input  logic [SLOTW-1:0] commit_slot_i,
  input  logic [4:0]       commit_rf_waddr_i,
  input  logic             flush_i,
  input  logic [SLOTW-1:0] lookup_slot_i,
  output logic             lookup_val_o,
  output logic [DW-1:0]    lookup_data_o,
  output logic             rf_wen_o,
  output logic [4:0]       rf_waddr_o,
  output logic [DW-1:0]    rf_wdata_o,
  output logic [SLOTW:0]   occupancy_o,
  output logic             err_commit_empty_o,
  output logic             err_fill_overwrite_o
);

  localparam int unsigned OCCW = SLOTW + 1;

  logic [NSLOTS-1:0] valid_q, valid_d;
  logic [DW-1:0]     data_q [NSLOTS];
  logic [OCCW-1:0]   occ_q, occ_d;
  logic              rf_wen_q, rf_wen_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]     rf_wdata_q, rf_wdata_d;
  logic              err_ce_q, err_ce_d;
  logic              err_fo_q, err_fo_d;

  logic              same_slot;
  logic              commit_fwd;
  logic              commit_has;
  logic [DW-1:0]     commit_sel;
  logic              occ_inc;
  logic              occ_dec;

  // Bypass lookup: a same-cycle fill wins over the stored array value
  always_comb begin
    lookup_val_o  = valid_q[lookup_slot_i];
    lookup_data_o = data_q[lookup_slot_i];
    if (fill_val_i && (fill_slot_i == lookup_slot_i)) begin
      lookup_val_o  = 1'b1;
      lookup_data_o = fill_data_i;
    end
  end

  // Next-state: slot valid bits, occupancy, RF write port and sticky errors
  always_comb begin
    valid_d    = valid_q;
    occ_d      = occ_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_ce_d   = err_ce_q;
    err_fo_d   = err_fo_q;

    commit_fwd = fill_val_i && (fill_slot_i == commit_slot_i);
    same_slot  = commit_wen_i && commit_fwd;
    commit_has = valid_q[commit_slot_i] | commit_fwd;
    commit_sel = commit_fwd ? fill_data_i : data_q[commit_slot_i];
    // A same-slot fill+commit never raises the count; the slot ends empty
    occ_inc    = fill_val_i && !valid_q[fill_slot_i] && !same_slot;
    occ_dec    = commit_wen_i && valid_q[commit_slot_i];

    if (flush_i) begin
      valid_d = '0;
      occ_d   = '0;
    end else begin
      if (fill_val_i) begin
        valid_d[fill_slot_i] = 1'b1;
        if (valid_q[fill_slot_i] && !same_slot) begin
          err_fo_d = 1'b1;
        end
      end
      // Commit is applied after fill so a same-slot pair leaves the slot free
      if (commit_wen_i) begin
        valid_d[commit_slot_i] = 1'b0;
        rf_wen_d   = commit_has && (commit_rf_waddr_i != 5'd0);
        rf_waddr_d = commit_rf_waddr_i;
        rf_wdata_d = commit_has ? commit_sel : '0;
        if (!commit_has) begin
          err_ce_d = 1'b1;
        end
      end
      occ_d = occ_q + OCCW'(occ_inc) - OCCW'(occ_dec);
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      occ_q      <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      err_ce_q   <= 1'b0;
      err_fo_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      occ_q      <= occ_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_ce_q   <= err_ce_d;
      err_fo_q   <= err_fo_d;
    end
  end

  // Payload array; contents are qualified by valid_q so no reset is needed
  always_ff @(posedge clk_i) begin
    if (fill_val_i && !flush_i) begin
      data_q[fill_slot_i] <= fill_data_i;
    end
  end

  assign rf_wen_o             = rf_wen_q;
  assign rf_waddr_o           = rf_waddr_q;
  assign rf_wdata_o           = rf_wdata_q;
  assign occupancy_o          = occ_q;
  assign err_commit_empty_o   = err_ce_q;
  assign err_fill_overwrite_o = err_fo_q;

endmodule

// File: tb/tb_parc_core_rob_result_buffer.sv
// Scoreboard bench for the ROB result buffer: expected RF writes are queued
// when commits are issued and popped by a monitor whenever rf_wen is seen.
module tb_parc_core_rob_result_buffer;

  logic        clk;
  logic        rst_n;
  logic        fill_val;
  logic [3:0]  fill_slot;
  logic [31:0] fill_data;
  logic        commit_wen;
  logic [3:0]  commit_slot;
  logic [4:0]  commit_waddr;
  logic        flush;
  logic [3:0]  lookup_slot;
  logic        lookup_val;
  logic [31:0] lookup_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  occupancy;
  logic        err_ce;
  logic        err_fo;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_exp_t;

  rf_exp_t exp_q [$];
  int n_pass  = 0;
  int n_total = 0;

  parc_core_rob_result_buffer dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .fill_val_i           (fill_val),
    .fill_slot_i          (fill_slot),
    .fill_data_i          (fill_data),
    .commit_wen_i         (commit_wen),
    .commit_slot_i        (commit_slot),
    .commit_rf_waddr_i    (commit_waddr),
    .flush_i              (flush),
    .lookup_slot_i        (lookup_slot),
    .lookup_val_o         (lookup_val),
    .lookup_data_o        (lookup_data),
    .rf_wen_o             (rf_wen),
    .rf_waddr_o           (rf_waddr),
    .rf_wdata_o           (rf_wdata),
    .occupancy_o          (occupancy),
    .err_commit_empty_o   (err_ce),
    .err_fill_overwrite_o (err_fo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every RF write must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rf_unexpected: got write addr %0d data 0x%0h expected no write",
                 rf_waddr, rf_wdata);
      end else begin
        rf_exp_t e;
        e = exp_q.pop_front();
        chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
        chk("rf_wdata", rf_wdata, e.wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fill_val   = 1'b0;
    commit_wen = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic do_fill(input logic [3:0] s, input logic [31:0] d);
    fill_val  = 1'b1;
    fill_slot = s;
    fill_data = d;
  endtask

  task automatic do_commit(input logic [3:0] s, input logic [4:0] a, input logic exp_wr,
                           input logic [31:0] d);
    rf_exp_t e;
    commit_wen   = 1'b1;
    commit_slot  = s;
    commit_waddr = a;
    if (exp_wr) begin
      e.waddr = a;
      e.wdata = d;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    logic [15:0] lv_mask;
    rst_n = 1'b0;
    fill_slot = '0; fill_data = '0; commit_slot = '0; commit_waddr = '0; lookup_slot = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_occ", 32'(occupancy), 32'd0);
    chk("reset_rf_wen", 32'(rf_wen), 32'd0);
    chk("reset_errs", 32'({err_ce, err_fo}), 32'd0);
    rst_n = 1'b1;
    step();

    // Fill slot 3, then commit it to r7
    do_fill(4'd3, 32'hDEADBEEF);
    lookup_slot = 4'd3;
    #1;
    chk("bypass_val", 32'(lookup_val), 32'd1);
    chk("bypass_data", lookup_data, 32'hDEADBEEF);
    step();
    idle_inputs();
    #1;
    chk("occ_after_fill", 32'(occupancy), 32'd1);
    chk("array_lookup_data", lookup_data, 32'hDEADBEEF);
    do_commit(4'd3, 5'd7, 1'b1, 32'hDEADBEEF);
    step();
    idle_inputs();
    chk("occ_after_commit", 32'(occupancy), 32'd0);
    step();

    // Same-cycle fill and commit of slot 5
    do_fill(4'd5, 32'h12345678);
    do_commit(4'd5, 5'd9, 1'b1, 32'h12345678);
    step();
    idle_inputs();
    lookup_slot = 4'd5;
    #1;
    chk("fwd_occ", 32'(occupancy), 32'd0);
    chk("fwd_slot_invalid", 32'(lookup_val), 32'd0);
    chk("fwd_no_errs", 32'({err_ce, err_fo}), 32'd0);

    // Fill all slots, then retire back-to-back
    for (int i = 0; i < 16; i++) begin
      do_fill(4'(i), 32'(i) * 32'h11);
      step();
    end
    idle_inputs();
    chk("full_occ", 32'(occupancy), 32'd16);
    for (int i = 0; i < 16; i++) begin
      do_commit(4'(i), 5'(i + 1), 1'b1, 32'(i) * 32'h11);
      step();
    end
    idle_inputs();
    chk("drained_occ", 32'(occupancy), 32'd0);
    chk("drain_no_errs", 32'({err_ce, err_fo}), 32'd0);
    step();

    // Commit of an empty slot, then commit to r0
    do_commit(4'd2, 5'd11, 1'b0, 32'd0);
    step();
    idle_inputs();
    chk("err_commit_empty_set", 32'(err_ce), 32'd1);
    repeat (2) step();
    chk("err_commit_empty_sticky", 32'(err_ce), 32'd1);
    do_fill(4'd4, 32'h000000AA);
    step();
    idle_inputs();
    do_commit(4'd4, 5'd0, 1'b0, 32'd0);
    step();
    idle_inputs();
    chk("r0_occ", 32'(occupancy), 32'd0);
    chk("r0_no_overwrite_err", 32'(err_fo), 32'd0);
    step();

    // Double fill of slot 6, then flush with three valid slots
    do_fill(4'd6, 32'h00000111);
    step();
    do_fill(4'd6, 32'h00000222);
    step();
    idle_inputs();
    lookup_slot = 4'd6;
    #1;
    chk("err_fill_overwrite_set", 32'(err_fo), 32'd1);
    chk("overwrite_data", lookup_data, 32'h00000222);
    chk("overwrite_occ", 32'(occupancy), 32'd1);
    do_fill(4'd7, 32'h7);
    step();
    do_fill(4'd8, 32'h8);
    step();
    idle_inputs();
    chk("pre_flush_occ", 32'(occupancy), 32'd3);
    flush = 1'b1;
    step();
    idle_inputs();
    chk("flush_occ", 32'(occupancy), 32'd0);
    lv_mask = '0;
    for (int i = 0; i < 16; i++) begin
      lookup_slot = 4'(i);
      #1;
      lv_mask[i] = lookup_val;
    end
    chk("flush_lookup_mask", 32'(lv_mask), 32'd0);
    chk("flush_keeps_errs", 32'({err_ce, err_fo}), 32'd3);

    // Asynchronous reset while an RF write is being presented
    do_fill(4'd1, 32'h00000055);
    step();
    idle_inputs();
    do_commit(4'd1, 5'd3, 1'b1, 32'h00000055);
    step();
    idle_inputs();
    @(negedge clk);
    #1;
    chk("pre_reset_rf_wen", 32'(rf_wen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rf_wen", 32'(rf_wen), 32'd0);
    chk("async_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("async_rf_wdata", rf_wdata, 32'd0);
    chk("async_occ", 32'(occupancy), 32'd0);
    chk("async_errs", 32'({err_ce, err_fo}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_reset_rf_wen", 32'(rf_wen), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/parc_core_rob_result_buffer.md
# parc_core_rob_result_buffer

Data-side companion to the core reorder buffer. It captures writeback results by ROB slot when functional units fill, holds them until the ROB retires that slot, then drives the architectural register file write port. The ROB tracks slot allocation and pending/valid state. This block holds the 32-bit payloads, consumes the ROB commit interface, and produces registered RF writes plus a combinational operand-lookup port for bypass.

## Interface
- NSLOTS, 16: number of result entries; equals ROB depth.
- SLOTW, 4: slot index width, log2(NSLOTS).
- DW, 32: result data width.
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- fill_val  in  1  result written this cycle
- fill_slot  in  SLOTW  ROB slot of the result
- fill_data  in  DW  result value
- commit_wen  in  1  ROB retires commit_slot this cycle
- commit_slot  in  SLOTW  slot being retired
- commit_rf_waddr  in  5  architectural destination register
- flush  in  1  synchronous squash of all held results
- lookup_slot  in  SLOTW  operand bypass query slot
- lookup_val  out  1  queried slot holds data (combinational)
- lookup_data  out  DW  queried slot data, or fill_data if same-cycle fill to that slot
- rf_wen  out  1  registered RF write enable
- rf_waddr  out  5  registered RF write address
- rf_wdata  out  DW  registered RF write data
- occupancy  out  SLOTW+1  count of slots holding data, 0..NSLOTS
- err_commit_empty  out  1  sticky: commit to a slot without data
- err_fill_overwrite  out  1  sticky: fill to a slot already holding data

## Operation
- State per slot: valid bit and DW data register. No head/tail pointers here; slot indices come from the ROB.
- Fill: on fill_val, data[fill_slot] <= fill_data and valid[fill_slot] <= 1. If the slot is already valid and not being committed this cycle, overwrite and set err_fill_overwrite.
- Commit: on commit_wen, the write data is fill_data if fill_val && fill_slot == commit_slot, otherwise data[commit_slot]. Next edge: rf_wen <= 1 if (slot valid or forwarded) and commit_rf_waddr != 0; rf_waddr <= commit_rf_waddr; rf_wdata <= selected data; valid[commit_slot] <= 0.
- Commit with no valid and no forwarded data: rf_wen <= 0, set err_commit_empty, clear valid.
- Fill and commit to the same slot in one cycle: data is forwarded, the slot ends invalid, and err_fill_overwrite is not set.
- Fill and commit to different slots in one cycle: both take effect.
- Register 0: a commit with waddr 0 frees the slot and suppresses rf_wen; this is not an error.
- flush: all valid bits clear at the next edge and rf_wen <= 0. A fill or commit in the same cycle is ignored. Sticky errors are kept.
- occupancy is the popcount of valid after the update, maintained as an up/down counter: +1 for a fill to an invalid slot, -1 for a commit of a valid slot, net 0 for same-slot fill+commit. It never leaves 0..NSLOTS.
- lookup is purely combinational: lookup_val = valid[lookup_slot] | (fill_val && fill_slot == lookup_slot).
- Sticky errors clear only on reset.

## Timing
- Reset (reset low, asynchronous): all valid = 0, occupancy = 0, rf_wen = 0, rf_waddr = 0, rf_wdata = 0, both error flags = 0. Data array contents are don't-care.
- Fill latency: data is visible on lookup in the same cycle (bypass) and from the array after 1 edge.
- Commit latency: commit_wen in cycle N gives rf_wen/rf_waddr/rf_wdata valid for exactly cycle N+1, with no backpressure. Back-to-back commits give back-to-back RF writes.
- A commit in cycle N+1 to a slot freed in cycle N sees the slot invalid.
- Reset asserted mid-commit: the pending rf_wen is dropped immediately and no write issues after reset releases.

## Test plan
- Reset, fill slot 3 with 0xDEADBEEF, commit slot 3 with waddr 7 the next cycle -> one cycle later rf_wen=1, rf_waddr=7, rf_wdata=0xDEADBEEF; occupancy goes 0→1→0.
- Fill and commit slot 5 in the same cycle with data 0x12345678, waddr 9 -> RF write of 0x12345678 next cycle, slot 5 invalid, occupancy unchanged, no error flags.
- Fill all 16 slots with value slot*0x11, then commit slots 0..15 back-to-back with waddr = slot+1 -> 16 consecutive RF writes with matching data, occupancy ends at 16 then 0, no errors.
- Commit slot 2 with nothing filled -> rf_wen stays 0, err_commit_empty=1 and stays set; commit slot 4 after filling with waddr 0 -> rf_wen 0, no error.
- Fill slot 6 twice without a commit in between -> err_fill_overwrite=1 and the second value is retained; flush with 3 slots valid -> occupancy 0 next edge, lookup_val 0 for all slots.
- Assert reset asynchronously while rf_wen=1 -> rf_wen drops before the next edge and all outputs take their reset values.
